// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: serialises command/data bytes onto a 4-bit HD44780 bus.
// A full byte goes out as two enable strobes (high nibble first). A single
// nibble transfer uses one strobe. Clear/home commands add a settle period.
// The block accepts one transfer at a time and does not queue requests.
module lcd_nibble_tx #(
  parameter int EN_CYCLES   = 1,
  parameter int GAP_CYCLES  = 1,
  parameter int LONG_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic       in_nib,
  input  logic [7:0] in_byte,
  output logic       en,
  output logic       rs,
  output logic [3:0] data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HI_EN     = 3'd1,
    S_HI_GAP    = 3'd2,
    S_LO_EN     = 3'd3,
    S_LO_GAP    = 3'd4,
    S_LONG_WAIT = 3'd5
  } state_t;

  // Counter load values. Each phase lasts (load + 1) cycles.
  localparam logic [7:0] EN_LOAD   = 8'(EN_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] LONG_LOAD = (LONG_CYCLES > 0) ? 8'(LONG_CYCLES - 1) : 8'd0;
  localparam logic       LONG_ON   = (LONG_CYCLES > 0) ? 1'b1 : 1'b0;

  // Clear-display (0x01) and return-home (0x02/0x03) commands need extra
  // settle time on the panel. Nibble transfers never count as these commands.
  function automatic logic is_clear_home(input logic       rs_f,
                                         input logic       nib_f,
                                         input logic [7:0] byte_f);
    logic hit;
    hit = (byte_f == 8'h01) || (byte_f == 8'h02) || (byte_f == 8'h03);
    return (rs_f == 1'b0) && (nib_f == 1'b0) && hit;
  endfunction

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_byte;
  logic       r_rs;
  logic       r_nib;
  logic       r_en;
  logic       r_rs_out;
  logic [3:0] r_data;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_byte_nxt;
  logic       w_rs_nxt;
  logic       w_nib_nxt;
  logic       w_en_nxt;
  logic       w_rs_out_nxt;
  logic [3:0] w_data_nxt;
  logic       w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 8'd0);

  // in_ready is decoded from the state register only.
  assign in_ready = (r_state == S_IDLE);
  assign busy     = ~in_ready;
  assign en       = r_en;
  assign rs       = r_rs_out;
  assign data     = r_data;

  // State register. Reset returns the FSM to IDLE and abandons any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase counter, latched transfer and bus outputs. Reset drops en at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 8'd0;
      r_byte   <= 8'd0;
      r_rs     <= 1'b0;
      r_nib    <= 1'b0;
      r_en     <= 1'b0;
      r_rs_out <= 1'b0;
      r_data   <= 4'd0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_byte   <= w_byte_nxt;
      r_rs     <= w_rs_nxt;
      r_nib    <= w_nib_nxt;
      r_en     <= w_en_nxt;
      r_rs_out <= w_rs_out_nxt;
      r_data   <= w_data_nxt;
    end
  end

  // Next-state and next-output logic. rs/data change only when a strobe starts.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_byte_nxt   = r_byte;
    w_rs_nxt     = r_rs;
    w_nib_nxt    = r_nib;
    w_en_nxt     = r_en;
    w_rs_out_nxt = r_rs_out;
    w_data_nxt   = r_data;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_byte_nxt   = in_byte;
          w_rs_nxt     = in_rs;
          w_nib_nxt    = in_nib;
          w_en_nxt     = 1'b1;
          w_rs_out_nxt = in_rs;
          w_cnt_nxt    = EN_LOAD;
          if (in_nib) begin
            w_state_nxt = S_LO_EN;
            w_data_nxt  = in_byte[3:0];
          end else begin
            w_state_nxt = S_HI_EN;
            w_data_nxt  = in_byte[7:4];
          end
        end else begin
          w_en_nxt  = 1'b0;
          w_cnt_nxt = 8'd0;
        end
      end

      S_HI_EN: begin
        if (w_cnt_zero) begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_HI_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_HI_GAP: begin
        if (w_cnt_zero) begin
          w_en_nxt    = 1'b1;
          w_data_nxt  = r_byte[3:0];
          w_state_nxt = S_LO_EN;
          w_cnt_nxt   = EN_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_LO_EN: begin
        if (w_cnt_zero) begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_LO_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_LO_GAP: begin
        if (w_cnt_zero) begin
          if (LONG_ON && is_clear_home(r_rs, r_nib, r_byte)) begin
            w_state_nxt = S_LONG_WAIT;
            w_cnt_nxt   = LONG_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_LONG_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

endmodule
